// File: rtl/core_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_opcodes
// Shared definitions for the instruction sequencer: the RV32I major opcodes
// it recognises, the sequencer state enum and small opcode-class helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package risc_v_opcodes;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_e;

    // Any opcode outside this set is illegal and stops the core with a trap.
    function automatic logic is_known_opcode(input logic [6:0] op);
        return (op == OP_LUI)    || (op == OP_AUIPC)   || (op == OP_JAL)     ||
               (op == OP_JALR)   || (op == OP_BRANCH)  || (op == OP_LOAD)    ||
               (op == OP_STORE)  || (op == OP_ALU_IMM) || (op == OP_ALU_REG) ||
               (op == OP_SYSTEM);
    endfunction

    // Opcodes that produce a destination-register result.
    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_LUI)  || (op == OP_AUIPC) || (op == OP_JAL)     ||
               (op == OP_JALR) || (op == OP_LOAD)  || (op == OP_ALU_IMM) ||
               (op == OP_ALU_REG);
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory system (slave).
//   imem_req/imem_addr   : fetch request and address (master -> slave)
//   imem_ready/imem_rdata: fetch completion and instruction word (slave -> master)
//   dmem_req/dmem_we     : data access request, store qualifier (master -> slave)
//   dmem_ready           : data access completion (slave -> master)
// -----------------------------------------------------------------------------
interface core_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/core_sequencer_pc.sv
// -----------------------------------------------------------------------------
// program_counter
// Holds the architectural PC and the next-PC value captured during EXEC.
//   clk, areset        : clock, asynchronous active-high reset
//   capture_en         : latch next_pc_candidate into the next-PC register
//   take_target        : select target_addr instead of pc+4
//   target_addr        : jump/branch target from the datapath
//   update_en          : commit the captured next PC into pc (on retire)
//   pc                 : current program counter
//   next_pc_candidate  : combinational next PC, used for alignment checking
// -----------------------------------------------------------------------------
module program_counter #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        capture_en,
    input  logic        take_target,
    input  logic [31:0] target_addr,
    input  logic        update_en,
    output logic [31:0] pc,
    output logic [31:0] next_pc_candidate
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] next_pc_q;
    logic [31:0] next_pc_d;

    // pc+4 wraps naturally at 2^32.
    assign next_pc_candidate = take_target ? target_addr : (pc_q + 32'd4);

    always_comb begin
        next_pc_d = next_pc_q;
        if (capture_en) begin
            next_pc_d = next_pc_candidate;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (update_en) begin
            pc_d = next_pc_q;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
        end else begin
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB,
// with an absorbing HALT state for SYSTEM, illegal opcodes and misaligned
// next-PC values.
//   clk, areset   : clock, asynchronous active-high reset
//   bus           : instruction/data memory handshakes (master side)
//   branch_taken  : ALU branch result, sampled in EXEC
//   target_addr   : jump/branch target, sampled in EXEC
//   instr         : latched instruction word for the decoder
//   pc            : current program counter (also the fetch address)
//   reg_we        : register-file write strobe (WB only)
//   retire        : one-cycle pulse per completed instruction
//   instret       : retired-instruction counter (wraps)
//   halted, trap  : core stopped; trap marks an error cause
// -----------------------------------------------------------------------------
module core_sequencer
    import risc_v_opcodes::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             areset,
    core_sequencer_if.master bus,
    input  logic             branch_taken,
    input  logic [31:0]      target_addr,
    output logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic             reg_we,
    output logic             retire,
    output logic [31:0]      instret,
    output logic             halted,
    output logic             trap
);

    seq_state_e  state_q;
    seq_state_e  state_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        trap_q;
    logic        trap_d;
    logic        trap_set;

    logic        pc_capture;
    logic        pc_update;
    logic        take_target;
    logic [31:0] pc_cur;
    logic [31:0] next_pc_candidate;

    logic [6:0]  opcode;
    logic [4:0]  rd;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];

    // Only meaningful while capture is enabled (EXEC).
    assign take_target = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                         ((opcode == OP_BRANCH) && branch_taken);

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk               (clk),
        .areset            (areset),
        .capture_en        (pc_capture),
        .take_target       (take_target),
        .target_addr       (target_addr),
        .update_en         (pc_update),
        .pc                (pc_cur),
        .next_pc_candidate (next_pc_candidate)
    );

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        reg_we       = 1'b0;
        retire       = 1'b0;
        pc_capture   = 1'b0;
        pc_update    = 1'b0;
        trap_set     = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                // Reset parks the FSM in FETCH; keep the request quiet until
                // reset is actually released.
                bus.imem_req = !areset;
                if (bus.imem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!is_known_opcode(opcode)) begin
                    state_d  = ST_HALT;
                    trap_set = 1'b1;
                end else if (opcode == OP_SYSTEM) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pc_capture = 1'b1;
                // A misaligned next PC stops the core before anything retires.
                if (next_pc_candidate[1:0] != 2'b00) begin
                    state_d  = ST_HALT;
                    trap_set = 1'b1;
                end else if (is_mem_op(opcode)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (opcode == OP_STORE);
                if (bus.dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        // Stores have no writeback; they complete here.
                        retire    = 1'b1;
                        pc_update = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we    = writes_rd(opcode) && (rd != 5'd0);
                retire    = 1'b1;
                pc_update = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        if ((state_q == ST_FETCH) && bus.imem_ready) begin
            instr_d = bus.imem_rdata;
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_comb begin
        trap_d = trap_q | trap_set;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
            trap_q    <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
        end
    end

    assign bus.imem_addr = pc_cur;
    assign pc            = pc_cur;
    assign instr         = instr_q;
    assign instret       = instret_q;
    assign halted        = (state_q == ST_HALT);
    assign trap          = trap_q;

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, is the instruction register value after reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 areset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address; equals pc.
REQ-007 imem_ready  input  1  fetch data valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 dmem_req  output  1  data access request.
REQ-010 dmem_we  output  1  data access is a store.
REQ-011 dmem_ready  input  1  data access complete this cycle.
REQ-012 branch_taken  input  1  branch comparison result from the ALU, valid in EXEC.
REQ-013 target_addr  input  32  jump/branch target from the datapath, valid in EXEC.
REQ-014 instr  output  32  latched instruction, fed to the decoder.
REQ-015 pc  output  32  current program counter.
REQ-016 reg_we  output  1  register-file write strobe.
REQ-017 retire  output  1  one-cycle pulse per completed instruction.
REQ-018 instret  output  32  retired-instruction count.
REQ-019 halted  output  1  sequencer stopped in HALT.
REQ-020 trap  output  1  halt cause was illegal opcode or misaligned target.

Function
REQ-021 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-022 FETCH: imem_req=1 until imem_ready; on ready, instr<=imem_rdata and go to DECODE; imem_addr held stable while waiting.
REQ-023 DECODE: classify instr[6:0]; opcode other than LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_IMM, ALU_REG or SYSTEM -> HALT with trap=1; SYSTEM -> HALT with trap=0; else -> EXEC, one cycle.
REQ-024 EXEC: one cycle; LOAD/STORE -> MEM; all others -> WB; capture next_pc = target_addr for JAL, JALR or (BRANCH and branch_taken), else pc+4 (mod 2^32).
REQ-025 EXEC: captured next_pc[1:0]!=0 -> HALT with trap=1; pc unchanged; no retire.
REQ-026 MEM: dmem_req=1, dmem_we=1 only for STORE; held until dmem_ready; LOAD -> WB; STORE -> FETCH with pc<=next_pc and retire.
REQ-027 WB: one cycle; reg_we=1 for LUI, AUIPC, JAL, JALR, ALU_IMM, ALU_REG, LOAD when instr[11:7]!=0; reg_we=0 for BRANCH; pc<=next_pc; retire=1; -> FETCH.
REQ-028 Latency without wait states: ALU/branch/jump 4 cycles, load 5, store 4.
REQ-029 instret increments by 1 on every retire and wraps 32'hFFFF_FFFF -> 0.
REQ-030 HALT is absorbing; only areset leaves it; all request and strobe outputs are 0 in HALT.
REQ-031 imem_req and dmem_req SHALL never be 1 in the same cycle.

Reset
REQ-032 On areset, immediately: state=FETCH, pc=RESET_PC, instr=NOP_INSTR, instret=0, and imem_req, dmem_req, dmem_we, reg_we, retire, halted, trap all 0.
REQ-033 areset asserted mid-handshake SHALL abandon the access; no retire, no register write, no pc update.
REQ-034 First imem_req=1 in the first cycle after areset deasserts.

Structure
REQ-035 Opcode constants and the state enum typedef SHALL reside in the shared risc_v_opcodes package.
REQ-036 The pc register and next_pc capture SHALL be one sub-module, program_counter; the FSM and instret counter stay in core_sequencer.

Verification
REQ-037 ADDI x1 (32'h0050_0093) at pc 0, imem_ready immediate -> reg_we pulse in cycle 4, pc=4, instret=1.
REQ-038 BEQ taken, target_addr=32'h40 -> pc=32'h40, reg_we=0, retire=1; not taken -> pc=pc+4.
REQ-039 LW with dmem_ready held low 3 cycles -> dmem_req stays 1 for 4 cycles, dmem_we=0, then WB reg_we=1.
REQ-040 Opcode 7'b0000000 -> halted=1, trap=1, no retire; 32'h0000_0073 -> halted=1, trap=0.
REQ-041 JALR with target_addr=32'h102 -> HALT, trap=1, pc unchanged; areset mid-MEM -> dmem_req=0 at once, pc=RESET_PC.
